// File: rtl/cpu6502_seq_if.sv
// rtl/cpu6502_seq_if.sv - control/status bundle between the 6502 datapath and its microcode sequencer
interface cpu6502_seq_if #(
  parameter int STATE_W = 6,
  parameter int CYC_W   = 4
);
  logic [7:0]         IR;
  logic               RDY;
  logic               write_back;
  logic               CO;
  logic               store;
  logic               cond_true;
  logic               backwards;
  logic               I_flag;
  logic               nmi;
  logic               irq;
  logic [STATE_W-1:0] outstate;
  logic               sync;
  logic [1:0]         vec_sel;
  logic [CYC_W-1:0]   cyc_cnt;

  modport master (
    output IR, RDY, write_back, CO, store, cond_true, backwards, I_flag, nmi, irq,
    input  outstate, sync, vec_sel, cyc_cnt
  );

  modport slave (
    input  IR, RDY, write_back, CO, store, cond_true, backwards, I_flag, nmi, irq,
    output outstate, sync, vec_sel, cyc_cnt
  );
endinterface

// File: rtl/cpu6502_seq.sv
// rtl/cpu6502_seq.sv - 6502 microcode sequencer with interrupt entry and optional 65C02 decode
// Macro FSM_CYCCNT_EN enables the per-instruction cycle counter on cyc_cnt.
module cpu6502_seq #(
  parameter int CMOS    = 0,
  parameter int STATE_W = 6,
  parameter int CYC_W   = 4
) (
  input logic          clk,
  input logic          reset_n,
  cpu6502_seq_if.slave bus
);

  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_REG    = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_ZP0    = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_ZPX0   = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_ZPX1   = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_ABS0   = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_ABS1   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ABSX0  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ABSX1  = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_ABSX2  = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_INDX0  = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_INDX1  = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_INDX2  = STATE_W'(12);
  localparam logic [STATE_W-1:0] S_INDX3  = STATE_W'(13);
  localparam logic [STATE_W-1:0] S_INDY0  = STATE_W'(14);
  localparam logic [STATE_W-1:0] S_INDY1  = STATE_W'(15);
  localparam logic [STATE_W-1:0] S_INDY2  = STATE_W'(16);
  localparam logic [STATE_W-1:0] S_INDY3  = STATE_W'(17);
  localparam logic [STATE_W-1:0] S_READ   = STATE_W'(18);
  localparam logic [STATE_W-1:0] S_WRITE  = STATE_W'(19);
  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(20);
  localparam logic [STATE_W-1:0] S_PUSH0  = STATE_W'(21);
  localparam logic [STATE_W-1:0] S_PUSH1  = STATE_W'(22);
  localparam logic [STATE_W-1:0] S_PULL0  = STATE_W'(23);
  localparam logic [STATE_W-1:0] S_PULL1  = STATE_W'(24);
  localparam logic [STATE_W-1:0] S_PULL2  = STATE_W'(25);
  localparam logic [STATE_W-1:0] S_JSR0   = STATE_W'(26);
  localparam logic [STATE_W-1:0] S_JSR1   = STATE_W'(27);
  localparam logic [STATE_W-1:0] S_JSR2   = STATE_W'(28);
  localparam logic [STATE_W-1:0] S_JSR3   = STATE_W'(29);
  localparam logic [STATE_W-1:0] S_RTI0   = STATE_W'(30);
  localparam logic [STATE_W-1:0] S_RTI1   = STATE_W'(31);
  localparam logic [STATE_W-1:0] S_RTI2   = STATE_W'(32);
  localparam logic [STATE_W-1:0] S_RTI3   = STATE_W'(33);
  localparam logic [STATE_W-1:0] S_RTI4   = STATE_W'(34);
  localparam logic [STATE_W-1:0] S_RTS0   = STATE_W'(35);
  localparam logic [STATE_W-1:0] S_RTS1   = STATE_W'(36);
  localparam logic [STATE_W-1:0] S_RTS2   = STATE_W'(37);
  localparam logic [STATE_W-1:0] S_RTS3   = STATE_W'(38);
  localparam logic [STATE_W-1:0] S_BRK0   = STATE_W'(39);
  localparam logic [STATE_W-1:0] S_BRK1   = STATE_W'(40);
  localparam logic [STATE_W-1:0] S_BRK2   = STATE_W'(41);
  localparam logic [STATE_W-1:0] S_BRK3   = STATE_W'(42);
  localparam logic [STATE_W-1:0] S_BRA0   = STATE_W'(43);
  localparam logic [STATE_W-1:0] S_BRA1   = STATE_W'(44);
  localparam logic [STATE_W-1:0] S_BRA2   = STATE_W'(45);
  localparam logic [STATE_W-1:0] S_JMP0   = STATE_W'(46);
  localparam logic [STATE_W-1:0] S_JMP1   = STATE_W'(47);
  localparam logic [STATE_W-1:0] S_JMPI0  = STATE_W'(48);
  localparam logic [STATE_W-1:0] S_JMPI1  = STATE_W'(49);
  localparam logic [STATE_W-1:0] S_ZPI0   = STATE_W'(50);
  localparam logic [STATE_W-1:0] S_ZPI1   = STATE_W'(51);

  logic [STATE_W-1:0] state, state_nxt;
  logic [1:0]         vec_q, vec_nxt;
  logic               nmi_q, nmi_pend, take_nmi;

  // First match wins; the 65C02 opcodes are checked ahead of the NMOS columns.
  function automatic logic [STATE_W-1:0] decode_op(input logic [7:0] op);
    logic [STATE_W-1:0] s;
    if      (CMOS != 0 && op == 8'h80)                   s = S_BRA0;
    else if (CMOS != 0 && (op == 8'h5A || op == 8'hDA))  s = S_PUSH0;
    else if (CMOS != 0 && (op == 8'h7A || op == 8'hFA))  s = S_PULL0;
    else if (CMOS != 0 && (op ==? 8'b???1_0010))         s = S_ZPI0;
    else if (op == 8'h00)                                s = S_BRK0;
    else if (op == 8'h20)                                s = S_JSR0;
    else if (op == 8'h2C)                                s = S_ABS0;
    else if (op == 8'h40)                                s = S_RTI0;
    else if (op == 8'h4C)                                s = S_JMP0;
    else if (op == 8'h60)                                s = S_RTS0;
    else if (op == 8'h6C)                                s = S_JMPI0;
    else if (op ==? 8'b0?00_1000)                        s = S_PUSH0;
    else if (op ==? 8'b0?10_1000)                        s = S_PULL0;
    else if (op ==? 8'b0??1_1000)                        s = S_REG;
    else if (op ==? 8'b1??0_00?0)                        s = S_FETCH;
    else if (op ==? 8'b1??0_1100)                        s = S_ABS0;
    else if (op ==? 8'b1???_1000)                        s = S_REG;
    else if (op ==? 8'b???0_0001)                        s = S_INDX0;
    else if (op ==? 8'b???0_01??)                        s = S_ZP0;
    else if (op ==? 8'b???0_1001)                        s = S_FETCH;
    else if (op ==? 8'b???0_1101 || op ==? 8'b???0_1110) s = S_ABS0;
    else if (op ==? 8'b???1_0000)                        s = S_BRA0;
    else if (op ==? 8'b???1_0001)                        s = S_INDY0;
    else if (op ==? 8'b???1_01??)                        s = S_ZPX0;
    else if (op ==? 8'b???1_1001)                        s = S_ABSX0;
    else if (op ==? 8'b???1_11??)                        s = S_ABSX0;
    else if (op ==? 8'b????_1010)                        s = S_REG;
    else                                                 s = S_DECODE;
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_BRK0;
      vec_q    <= 2'd3;
      nmi_q    <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      vec_q    <= vec_nxt;
      nmi_q    <= bus.nmi;
      // A fresh edge in the consuming cycle keeps the request pending.
      nmi_pend <= (bus.nmi & ~nmi_q) | (nmi_pend & ~take_nmi);
    end
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_q;
    take_nmi  = 1'b0;
    if (bus.RDY) begin
      case (state)
        S_DECODE: begin
          if (nmi_pend) begin
            state_nxt = S_BRK0;
            vec_nxt   = 2'd2;
            take_nmi  = 1'b1;
          end else if (bus.irq && !bus.I_flag) begin
            state_nxt = S_BRK0;
            vec_nxt   = 2'd1;
          end else begin
            state_nxt = decode_op(bus.IR);
            if (bus.IR == 8'h00) vec_nxt = 2'd0;
          end
        end
        S_ZP0, S_ZPX1, S_ABS1, S_ABSX2:
          state_nxt = bus.write_back ? S_READ : S_FETCH;
        S_ZPX0:  state_nxt = S_ZPX1;
        S_ABS0:  state_nxt = S_ABS1;
        S_ABSX0: state_nxt = S_ABSX1;
        S_ABSX1: state_nxt = (bus.CO | bus.store | bus.write_back) ? S_ABSX2 : S_FETCH;
        S_INDX0: state_nxt = S_INDX1;
        S_INDX1: state_nxt = S_INDX2;
        S_INDX2: state_nxt = S_INDX3;
        S_INDX3: state_nxt = S_FETCH;
        S_INDY0: state_nxt = S_INDY1;
        S_INDY1: state_nxt = S_INDY2;
        S_INDY2: state_nxt = (bus.CO | bus.store) ? S_INDY3 : S_FETCH;
        S_INDY3: state_nxt = S_FETCH;
        S_READ:  state_nxt = S_WRITE;
        S_WRITE: state_nxt = S_FETCH;
        S_FETCH, S_REG: state_nxt = S_DECODE;
        S_PUSH0: state_nxt = S_PUSH1;
        S_PUSH1: state_nxt = S_DECODE;
        S_PULL0: state_nxt = S_PULL1;
        S_PULL1: state_nxt = S_PULL2;
        S_PULL2: state_nxt = S_DECODE;
        S_JSR0:  state_nxt = S_JSR1;
        S_JSR1:  state_nxt = S_JSR2;
        S_JSR2:  state_nxt = S_JSR3;
        S_JSR3:  state_nxt = S_FETCH;
        S_RTI0:  state_nxt = S_RTI1;
        S_RTI1:  state_nxt = S_RTI2;
        S_RTI2:  state_nxt = S_RTI3;
        S_RTI3:  state_nxt = S_RTI4;
        S_RTI4:  state_nxt = S_DECODE;
        S_RTS0:  state_nxt = S_RTS1;
        S_RTS1:  state_nxt = S_RTS2;
        S_RTS2:  state_nxt = S_RTS3;
        S_RTS3:  state_nxt = S_FETCH;
        S_BRK0:  state_nxt = S_BRK1;
        S_BRK1:  state_nxt = S_BRK2;
        S_BRK2:  state_nxt = S_BRK3;
        S_BRK3:  state_nxt = S_JMP0;
        S_BRA0:  state_nxt = bus.cond_true ? S_BRA1 : S_DECODE;
        S_BRA1:  state_nxt = (bus.CO ^ bus.backwards) ? S_BRA2 : S_DECODE;
        S_BRA2:  state_nxt = S_DECODE;
        S_JMP0:  state_nxt = S_JMP1;
        S_JMP1:  state_nxt = S_DECODE;
        S_JMPI0: state_nxt = S_JMPI1;
        S_JMPI1: state_nxt = S_JMP0;
        S_ZPI0:  state_nxt = S_ZPI1;
        S_ZPI1:  state_nxt = S_FETCH;
        default: state_nxt = S_DECODE;
      endcase
    end
  end

  always_comb begin
    bus.outstate = state;
    bus.sync     = (state == S_DECODE);
    bus.vec_sel  = vec_q;
  end

`ifdef FSM_CYCCNT_EN
  logic [CYC_W-1:0] cyc_q;

  // Entering DECODE zeroes the count, so the first cycle after DECODE reads 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
    end else if (bus.RDY) begin
      if (state_nxt == S_DECODE) cyc_q <= '0;
      else if (!(&cyc_q))        cyc_q <= cyc_q + CYC_W'(1);
    end
  end

  assign bus.cyc_cnt = cyc_q;
`else
  assign bus.cyc_cnt = {CYC_W{1'b0}};
`endif

endmodule
